// File: rtl/r5p_soc_io_pkg.sv
// Shared I/O types for the r5p SoC peripherals: button debouncer FSM states.
package r5p_soc_io_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } deb_state_e;

endpackage

// File: rtl/r5p_button_debounce_ch.sv
// One debounced button channel: 2-flop sync, REL/CHK_P/PRS/CHK_R FSM, long-press counter.
// Raw edge to btn_o latency is 2 + DEB_CYC + 1 cycles; all outputs are registered.
module r5p_button_debounce_ch
  import r5p_soc_io_pkg::*;
#(
  parameter int   DEB_CYC = 270000,
  parameter int   HLD_CYC = 27000000,
  parameter logic ACT_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o,
  output logic btn_p,
  output logic btn_r,
  output logic btn_h
);

  localparam int DW = $clog2(DEB_CYC);
  localparam int HW = $clog2(HLD_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [HW-1:0] HLD_MAX  = HW'(HLD_CYC);
  localparam logic [HW-1:0] HLD_ONE  = HW'(1);

  logic [1:0]    sync_q;
  logic          s;
  deb_state_e    state_q;
  logic [DW-1:0] deb_cnt_q;
  logic          deb_done;
  logic          rel_fire;
  logic [HW-1:0] hold_q, hold_d;
  logic          btn_o_q, btn_p_q, btn_r_q, btn_h_q;

  // Synchronizer parks at the inactive raw level so a held button reads as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{ACT_LOW}};
    else     sync_q <= {sync_q[0], btn_i};
  end

  assign s        = sync_q[1] ^ ACT_LOW;
  assign deb_done = (deb_cnt_q == DEB_LAST);
  assign rel_fire = (state_q == CHK_R) && !s && deb_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REL;
      deb_cnt_q <= '0;
      btn_o_q   <= 1'b0;
      btn_p_q   <= 1'b0;
      btn_r_q   <= 1'b0;
    end else begin
      btn_p_q <= 1'b0;
      btn_r_q <= 1'b0;
      case (state_q)
        REL: begin
          if (s) begin
            state_q   <= CHK_P;
            deb_cnt_q <= '0;
          end
        end
        CHK_P: begin
          if (!s) begin
            state_q <= REL;
          end else if (deb_done) begin
            state_q <= PRS;
            btn_o_q <= 1'b1;
            btn_p_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + DEB_ONE;
          end
        end
        PRS: begin
          if (!s) begin
            state_q   <= CHK_R;
            deb_cnt_q <= '0;
          end
        end
        CHK_R: begin
          if (s) begin
            state_q <= PRS;
          end else if (deb_done) begin
            state_q <= REL;
            btn_o_q <= 1'b0;
            btn_r_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + DEB_ONE;
          end
        end
        default: state_q <= REL;
      endcase
    end
  end

  // Hold count runs while btn_o is high (including CHK_R bounces) and clears with the release pulse.
  always_comb begin
    hold_d = hold_q;
    if (rel_fire)
      hold_d = '0;
    else if (btn_o_q && (hold_q != HLD_MAX))
      hold_d = hold_q + HLD_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      btn_h_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      btn_h_q <= (hold_d == HLD_MAX);
    end
  end

  assign btn_o = btn_o_q;
  assign btn_p = btn_p_q;
  assign btn_r = btn_r_q;
  assign btn_h = btn_h_q;

endmodule

// File: rtl/r5p_button_debounce.sv
// Multi-channel button debouncer: BTN_NUM independent channels with press/release pulses
// and a long-press level; each channel adds 2 + DEB_CYC + 1 cycles of latency.
module r5p_button_debounce #(
  parameter int   BTN_NUM = 2,
  parameter int   DEB_CYC = 270000,
  parameter int   HLD_CYC = 27000000,
  parameter logic ACT_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_NUM-1:0] btn_i,
  output logic [BTN_NUM-1:0] btn_o,
  output logic [BTN_NUM-1:0] btn_p,
  output logic [BTN_NUM-1:0] btn_r,
  output logic [BTN_NUM-1:0] btn_h
);

  for (genvar g = 0; g < BTN_NUM; g++) begin : g_ch
    r5p_button_debounce_ch #(
      .DEB_CYC (DEB_CYC),
      .HLD_CYC (HLD_CYC),
      .ACT_LOW (ACT_LOW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_i[g]),
      .btn_o (btn_o[g]),
      .btn_p (btn_p[g]),
      .btn_r (btn_r[g]),
      .btn_h (btn_h[g])
    );
  end

endmodule
